clk_counter: RTL and testbench
==============================

Name: clk_counter

Overview:
- Free-running modulo counter advanced by an integrated clock prescaler.
- `count` steps 0,1,…,COUNT_LIMIT,0,… and advances once every CLOCK_DELAY clock cycles.
- Used as a slow timebase or sequence index, e.g. a digit or LED scanner driven from a 12 MHz board clock.
- Also emits single-cycle `tick` and `wrap` strobes for downstream logic.

Parameters:
- COUNT_LIMIT, 9: last value `count` reaches before wrapping to 0. Legal range 0 ≤ COUNT_LIMIT ≤ 2**COUNT_WIDTH−1.
- COUNT_WIDTH, 4: bit width of `count`. Must be ≥1.
- CLOCK_DELAY, 4: clk cycles per `count` step. Must be ≥1. Prescaler width is max(1, $clog2(CLOCK_DELAY)).

Ports:
- clk  input  1  system clock. All logic is on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- count  output  COUNT_WIDTH  current count value, registered.
- tick  output  1  registered one-cycle strobe. High in each cycle in which `count` has just taken a new value.
- wrap  output  1  registered one-cycle strobe. High in the cycle in which `count` has just returned from COUNT_LIMIT to 0.

Interface: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Internal prescaler `pre` counts 0..CLOCK_DELAY−1 and then returns to 0.
- At a rising edge with rst=1: `pre`←0, `count`←0, `tick`←0, `wrap`←0. Reset overrides everything, including mid-count.
- Power-up: all registers initialise to 0 via declaration initialisers, so the sequence is defined on FPGA targets even without a reset pulse.
- At a rising edge with rst=0 and `pre`≠CLOCK_DELAY−1: `pre`←`pre`+1; `count` holds; `tick`←0, `wrap`←0.
- At a rising edge with rst=0 and `pre`=CLOCK_DELAY−1 (a step edge): `pre`←0; `tick`←1.
  - If `count`=COUNT_LIMIT: `count`←0 and `wrap`←1.
  - Otherwise: `count`←`count`+1 and `wrap`←0.
- Latency:
  - After reset is released, `count` reads 0 for exactly CLOCK_DELAY cycles, then reads 1.
  - The full period is (COUNT_LIMIT+1)×CLOCK_DELAY cycles.
- CLOCK_DELAY=1: every edge is a step edge. `count` increments every cycle and `tick` stays high continuously after the first edge.
- COUNT_LIMIT=0: `count` stays 0 and `wrap` pulses on every step.
- COUNT_LIMIT=2**COUNT_WIDTH−1: wraps via the explicit compare, never via overflow. `count` must never exceed COUNT_LIMIT.
- Illegal parameters (CLOCK_DELAY<1, COUNT_LIMIT out of range) are rejected at elaboration with a generate-time $error.

Optional Feature:
- Macro: CLK_COUNTER_HOLD_EN.
- When defined, adds input port `hold` (1 bit), placed after `rst`.
  - While hold=1 and rst=0: `pre` and `count` freeze, and `tick`/`wrap` are 0.
  - Releasing `hold` resumes counting from the frozen `pre` value, with no lost or extra cycles.
  - rst has priority over hold.
- When not defined: the port is absent and behaviour is exactly as above, i.e. always counting.

Decomposition:
- Package clk_counter_pkg holds:
  - function prescaler_width(delay) returning max(1, $clog2(delay));
  - default-value localparams DEF_COUNT_LIMIT=9, DEF_COUNT_WIDTH=4, DEF_CLOCK_DELAY=4.
- One sub-module, clk_prescaler:
  - parameter CLOCK_DELAY; ports clk, rst, hold (tied 0 when the feature is off), tick_next.
  - tick_next is high combinationally when `pre`=CLOCK_DELAY−1 and hold=0.
- The top level instantiates clk_prescaler and contains the count register, the compare against COUNT_LIMIT and the strobe registers.

Test Plan:
- Defaults (9,4,4), rst high for 2 cycles then low → `count`=0 for 4 cycles, 1 for the next 4, …, 9 for 4 cycles, then 0. `tick` is high 1 cycle in every 4. `wrap` is high only in the first cycle of `count`=0 after 9; period is 40 cycles.
- Reset asserted mid-count (`count`=6, `pre`=2) for 1 cycle → next cycle `count`=0 and all strobes 0. `count` first reads 1 exactly 4 cycles after rst falls.
- CLOCK_DELAY=1, COUNT_LIMIT=3 → `count` sequence 0,1,2,3,0,1… on consecutive cycles. `tick` is constantly 1 after the first edge; `wrap` is high every 4th cycle.
- COUNT_LIMIT=15, COUNT_WIDTH=4, CLOCK_DELAY=2 → `count` goes 15→0 with `wrap`=1. Verify no X values and period 32 cycles.
- COUNT_LIMIT=0 → `count` is always 0 and `wrap`=`tick`, pulsing every CLOCK_DELAY cycles.
- With CLK_COUNTER_HOLD_EN, hold=1 for 5 cycles while `count`=3, `pre`=1 → `count` stays 3 with no strobes. After release, `count`→4 exactly 3 cycles later.

Source files
------------

// File: rtl/clk_counter_pkg.sv
// Shared defaults and helpers for the clk_counter timebase.
package clk_counter_pkg;

    localparam int unsigned DEF_COUNT_LIMIT = 9;
    localparam int unsigned DEF_COUNT_WIDTH = 4;
    localparam int unsigned DEF_CLOCK_DELAY = 4;

    // Prescaler register width; a single bit is kept even when the delay is 1.
    function automatic int unsigned prescaler_width(input int unsigned delay);
        int unsigned w;
        w = $clog2(delay);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/clk_prescaler.sv
// Clock prescaler: counts 0..CLOCK_DELAY-1 and flags the last cycle of each period.
module clk_prescaler
    import clk_counter_pkg::*;
#(
    parameter int unsigned CLOCK_DELAY = DEF_CLOCK_DELAY
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic tick_next
);

    localparam int unsigned PW = prescaler_width(CLOCK_DELAY);
    localparam logic [PW-1:0] PreLast = PW'(CLOCK_DELAY - 1);

    // Power-up value keeps the sequence defined even without a reset pulse.
    logic [PW-1:0] pre_q = '0;
    logic [PW-1:0] pre_d;

    // Next prescaler value: wrap at the last cycle, freeze while held.
    always_comb begin
        pre_d = pre_q;
        if (!hold) begin
            pre_d = (pre_q == PreLast) ? '0 : pre_q + 1'b1;
        end
    end

    // Prescaler register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    assign tick_next = (pre_q == PreLast) && !hold;

endmodule

// File: rtl/clk_counter.sv
// Free-running modulo counter stepped by an integrated prescaler, with tick/wrap strobes.
// Optional macro CLK_COUNTER_HOLD_EN adds a 'hold' input that freezes the whole timebase.
module clk_counter
    import clk_counter_pkg::*;
#(
    parameter int unsigned COUNT_LIMIT = DEF_COUNT_LIMIT,
    parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int unsigned CLOCK_DELAY = DEF_CLOCK_DELAY
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef CLK_COUNTER_HOLD_EN
    input  logic                   hold,
`endif
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   tick,
    output logic                   wrap
);

    // Reject illegal configurations at elaboration.
    if (CLOCK_DELAY < 1) begin : g_bad_delay
        $error("clk_counter: CLOCK_DELAY must be >= 1");
    end
    if (COUNT_WIDTH < 1) begin : g_bad_width
        $error("clk_counter: COUNT_WIDTH must be >= 1");
    end
    if ((64'(COUNT_LIMIT) >> COUNT_WIDTH) != 64'd0) begin : g_bad_limit
        $error("clk_counter: COUNT_LIMIT does not fit in COUNT_WIDTH bits");
    end

    localparam logic [COUNT_WIDTH-1:0] Limit = COUNT_WIDTH'(COUNT_LIMIT);

    logic hold_int;
`ifdef CLK_COUNTER_HOLD_EN
    assign hold_int = hold;
`else
    assign hold_int = 1'b0;
`endif

    logic step;

    clk_prescaler #(
        .CLOCK_DELAY(CLOCK_DELAY)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold_int),
        .tick_next(step)
    );

    logic [COUNT_WIDTH-1:0] count_q = '0;
    logic                   tick_q  = 1'b0;
    logic                   wrap_q  = 1'b0;
    logic [COUNT_WIDTH-1:0] count_d;
    logic                   tick_d;
    logic                   wrap_d;

    // Next count and strobes; wrap uses an explicit compare so count never passes the limit.
    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (step) begin
            tick_d = 1'b1;
            if (count_q == Limit) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Count and strobe registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_clk_counter.sv
// Self-checking bench for clk_counter: four configurations run side by side against a
// behavioural model; expected outputs are queued per edge and compared one cycle phase later.
module tb_clk_counter;

    localparam int NDUT = 4;

    typedef struct {
        int pre;
        int count;
        bit tick;
        bit wrap;
    } model_t;

    typedef struct {
        int dut;
        int count;
        bit tick;
        bit wrap;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic hold_a = 1'b0;

    logic [3:0] cnt0, cnt1, cnt2, cnt3;
    logic       tk0, tk1, tk2, tk3;
    logic       wr0, wr1, wr2, wr3;

    logic [3:0] obs_count [NDUT];
    logic       obs_tick  [NDUT];
    logic       obs_wrap  [NDUT];

    model_t mdl [NDUT];
    exp_t   exp_q[$];
    int     vectors = 0;
    int     miscompares = 0;

    always #5 clk = ~clk;

    clk_counter #(.COUNT_LIMIT(9), .COUNT_WIDTH(4), .CLOCK_DELAY(4)) u_dut0 (
        .clk(clk), .rst(rst_a),
`ifdef CLK_COUNTER_HOLD_EN
        .hold(hold_a),
`endif
        .count(cnt0), .tick(tk0), .wrap(wr0));

    clk_counter #(.COUNT_LIMIT(3), .COUNT_WIDTH(4), .CLOCK_DELAY(1)) u_dut1 (
        .clk(clk), .rst(rst_b),
`ifdef CLK_COUNTER_HOLD_EN
        .hold(1'b0),
`endif
        .count(cnt1), .tick(tk1), .wrap(wr1));

    clk_counter #(.COUNT_LIMIT(15), .COUNT_WIDTH(4), .CLOCK_DELAY(2)) u_dut2 (
        .clk(clk), .rst(rst_b),
`ifdef CLK_COUNTER_HOLD_EN
        .hold(1'b0),
`endif
        .count(cnt2), .tick(tk2), .wrap(wr2));

    clk_counter #(.COUNT_LIMIT(0), .COUNT_WIDTH(4), .CLOCK_DELAY(3)) u_dut3 (
        .clk(clk), .rst(rst_b),
`ifdef CLK_COUNTER_HOLD_EN
        .hold(1'b0),
`endif
        .count(cnt3), .tick(tk3), .wrap(wr3));

    function automatic int lim_of(input int i);
        case (i)
            0: return 9;
            1: return 3;
            2: return 15;
            default: return 0;
        endcase
    endfunction

    function automatic int dly_of(input int i);
        case (i)
            0: return 4;
            1: return 1;
            2: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic model_t mstep(input model_t m, input bit r, input bit h,
                                     input int lim, input int dly);
        model_t n;
        n = m;
        n.tick = 1'b0;
        n.wrap = 1'b0;
        if (r) begin
            n.pre   = 0;
            n.count = 0;
        end else if (!h) begin
            if (m.pre == dly - 1) begin
                n.pre  = 0;
                n.tick = 1'b1;
                if (m.count == lim) begin
                    n.count = 0;
                    n.wrap  = 1'b1;
                end else begin
                    n.count = m.count + 1;
                end
            end else begin
                n.pre = m.pre + 1;
            end
        end
        return n;
    endfunction

    // One clock edge: drive inputs, advance the models, queue expectations, sample DUTs.
    task automatic step(input bit ra, input bit rb, input bit h);
        exp_t e;
        rst_a  = ra;
        rst_b  = rb;
        hold_a = h;
        @(posedge clk);
        for (int i = 0; i < NDUT; i++) begin
            mdl[i] = mstep(mdl[i], (i == 0) ? ra : rb, (i == 0) ? h : 1'b0,
                           lim_of(i), dly_of(i));
            e.dut   = i;
            e.count = mdl[i].count;
            e.tick  = mdl[i].tick;
            e.wrap  = mdl[i].wrap;
            exp_q.push_back(e);
        end
        #1;
        obs_count[0] = cnt0; obs_tick[0] = tk0; obs_wrap[0] = wr0;
        obs_count[1] = cnt1; obs_tick[1] = tk1; obs_wrap[1] = wr1;
        obs_count[2] = cnt2; obs_tick[2] = tk2; obs_wrap[2] = wr2;
        obs_count[3] = cnt3; obs_tick[3] = tk3; obs_wrap[3] = wr3;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            step(1'b1, 1'b1, 1'b0);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (obs_count[e.dut] !== 4'(e.count) || obs_tick[e.dut] !== e.tick ||
                    obs_wrap[e.dut] !== e.wrap) begin
                    miscompares++;
                    $display("FAIL reset dut%0d: got cnt=%0d tick=%b wrap=%b, want cnt=%0d tick=%b wrap=%b",
                             e.dut, obs_count[e.dut], obs_tick[e.dut], obs_wrap[e.dut],
                             e.count, e.tick, e.wrap);
                end
            end
        end
    endtask

    task automatic test_sequence();
        exp_t e;
        int   first_one = -1;
        int   first_wrap = -1;
        for (int k = 1; k <= 45; k++) begin
            step(1'b0, 1'b0, 1'b0);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (obs_count[e.dut] !== 4'(e.count) || obs_tick[e.dut] !== e.tick ||
                    obs_wrap[e.dut] !== e.wrap) begin
                    miscompares++;
                    $display("FAIL sequence dut%0d k=%0d: got cnt=%0d tick=%b wrap=%b, want cnt=%0d tick=%b wrap=%b",
                             e.dut, k, obs_count[e.dut], obs_tick[e.dut], obs_wrap[e.dut],
                             e.count, e.tick, e.wrap);
                end
            end
            if (first_one < 0 && obs_count[0] === 4'd1) first_one = k;
            if (first_wrap < 0 && obs_wrap[0] === 1'b1) first_wrap = k;
            vectors++;
            if (obs_wrap[3] !== obs_tick[3] || obs_count[3] !== 4'd0) begin
                miscompares++;
                $display("FAIL limit0 k=%0d: got cnt=%0d wrap=%b tick=%b, want cnt=0 wrap=tick",
                         k, obs_count[3], obs_wrap[3], obs_tick[3]);
            end
        end
        vectors++;
        if (first_one != 4) begin
            miscompares++;
            $display("FAIL first_step: got %0d, want 4", first_one);
        end
        vectors++;
        if (first_wrap != 40) begin
            miscompares++;
            $display("FAIL period40: got %0d, want 40", first_wrap);
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        int   first_one = -1;
        for (int k = 0; k < 32; k++) begin
            // edge 0 resets dut0, edges 1..26 bring it to count=6 pre=2, edge 27 resets mid-count
            step((k == 0) || (k == 27), 1'b0, 1'b0);
            if (k == 26) begin
                vectors++;
                if (obs_count[0] !== 4'd6) begin
                    miscompares++;
                    $display("FAIL mid_setup: got cnt=%0d, want 6", obs_count[0]);
                end
            end
            if (k > 27 && first_one < 0 && obs_count[0] === 4'd1) first_one = k - 27;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (obs_count[e.dut] !== 4'(e.count) || obs_tick[e.dut] !== e.tick ||
                    obs_wrap[e.dut] !== e.wrap) begin
                    miscompares++;
                    $display("FAIL mid_reset dut%0d k=%0d: got cnt=%0d tick=%b wrap=%b, want cnt=%0d tick=%b wrap=%b",
                             e.dut, k, obs_count[e.dut], obs_tick[e.dut], obs_wrap[e.dut],
                             e.count, e.tick, e.wrap);
                end
            end
        end
        vectors++;
        if (first_one != 4) begin
            miscompares++;
            $display("FAIL mid_reset_latency: got %0d, want 4", first_one);
        end
    endtask

    task automatic test_clock_delay_one();
        exp_t e;
        int   wraps = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b0, 1'b0);
            if (obs_wrap[1] === 1'b1) wraps++;
            vectors++;
            if (obs_tick[1] !== 1'b1) begin
                miscompares++;
                $display("FAIL cd1_tick k=%0d: got %b, want 1", k, obs_tick[1]);
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (obs_count[e.dut] !== 4'(e.count) || obs_tick[e.dut] !== e.tick ||
                    obs_wrap[e.dut] !== e.wrap) begin
                    miscompares++;
                    $display("FAIL cd1 dut%0d k=%0d: got cnt=%0d tick=%b wrap=%b, want cnt=%0d tick=%b wrap=%b",
                             e.dut, k, obs_count[e.dut], obs_tick[e.dut], obs_wrap[e.dut],
                             e.count, e.tick, e.wrap);
                end
            end
        end
        vectors++;
        if (wraps != 3) begin
            miscompares++;
            $display("FAIL cd1_wraps: got %0d, want 3", wraps);
        end
    endtask

    task automatic test_full_range();
        exp_t e;
        int   last_wrap = -1;
        int   periods = 0;
        for (int k = 0; k < 80; k++) begin
            step(1'b0, 1'b0, 1'b0);
            vectors++;
            if ($isunknown({cnt2, tk2, wr2})) begin
                miscompares++;
                $display("FAIL full_x k=%0d: got cnt=%b tick=%b wrap=%b, want known",
                         k, cnt2, tk2, wr2);
            end
            if (obs_wrap[2] === 1'b1) begin
                if (last_wrap >= 0) begin
                    periods++;
                    vectors++;
                    if (k - last_wrap != 32) begin
                        miscompares++;
                        $display("FAIL full_period: got %0d, want 32", k - last_wrap);
                    end
                end
                last_wrap = k;
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (obs_count[e.dut] !== 4'(e.count) || obs_tick[e.dut] !== e.tick ||
                    obs_wrap[e.dut] !== e.wrap) begin
                    miscompares++;
                    $display("FAIL full dut%0d k=%0d: got cnt=%0d tick=%b wrap=%b, want cnt=%0d tick=%b wrap=%b",
                             e.dut, k, obs_count[e.dut], obs_tick[e.dut], obs_wrap[e.dut],
                             e.count, e.tick, e.wrap);
                end
            end
        end
        vectors++;
        if (periods < 1) begin
            miscompares++;
            $display("FAIL full_wraps_seen: got %0d periods, want >=1", periods);
        end
    endtask

`ifdef CLK_COUNTER_HOLD_EN
    task automatic test_hold();
        exp_t e;
        // edge 0 resets dut0; edges 1..13 reach count=3 pre=1; 14..18 held; 19.. released
        for (int k = 0; k < 24; k++) begin
            step(k == 0, 1'b0, (k >= 14) && (k <= 18));
            if (k >= 14 && k <= 20) begin
                vectors++;
                if (obs_count[0] !== 4'd3 || obs_tick[0] !== 1'b0 || obs_wrap[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL hold_freeze k=%0d: got cnt=%0d tick=%b wrap=%b, want cnt=3 tick=0 wrap=0",
                             k, obs_count[0], obs_tick[0], obs_wrap[0]);
                end
            end
            if (k == 21) begin
                vectors++;
                if (obs_count[0] !== 4'd4 || obs_tick[0] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL hold_resume: got cnt=%0d tick=%b, want cnt=4 tick=1",
                             obs_count[0], obs_tick[0]);
                end
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (obs_count[e.dut] !== 4'(e.count) || obs_tick[e.dut] !== e.tick ||
                    obs_wrap[e.dut] !== e.wrap) begin
                    miscompares++;
                    $display("FAIL hold dut%0d k=%0d: got cnt=%0d tick=%b wrap=%b, want cnt=%0d tick=%b wrap=%b",
                             e.dut, k, obs_count[e.dut], obs_tick[e.dut], obs_wrap[e.dut],
                             e.count, e.tick, e.wrap);
                end
            end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            mdl[i].pre   = 0;
            mdl[i].count = 0;
            mdl[i].tick  = 1'b0;
            mdl[i].wrap  = 1'b0;
        end
        test_reset();
        test_sequence();
        test_mid_reset();
        test_clock_delay_one();
        test_full_range();
`ifdef CLK_COUNTER_HOLD_EN
        test_hold();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
